mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Memory-access pipeline stage between EX and WB. Registers EX results, runs data-memory
//  loads/stores over a req/ready handshake, stalls upstream while memory is busy, and
//  presents RW/DA/MD/F/Data/VxorN to the write-back stage (which selects BUS_D by MD).
// PARAMETERS
//  DATA_W       32  datapath width (F, store data, load data)
//  ADDR_W       32  memory address width; mem_addr = F[ADDR_W-1:0]
//  DA_W         5   destination register address width
//  TIMEOUT_CYC  16  WAIT cycles before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//  CLOCK      in   1       stage clock; all registers update on falling edge
//  RESET      in   1       synchronous, active-high
//  RW         in   1       EX: register write enable
//  DA         in   DA_W    EX: destination register
//  MD         in   2       EX: WB mux select (0=F, 1=load data, 2=VxorN)
//  MW         in   1       EX: memory write (store)
//  F          in   DATA_W  EX: ALU result / memory address
//  BUS_B      in   DATA_W  EX: store data
//  VxorN      in   1       EX: V^N flag for set-less-than
//  STALL      out  1       1 = EX/ID must hold; stage register does not load
//  mem_req    out  1       memory request
//  mem_we     out  1       1 = store, 0 = load; valid with mem_req
//  mem_addr   out  ADDR_W  request address
//  mem_wdata  out  DATA_W  store data
//  mem_rdata  in   DATA_W  load data; sampled only on edge with mem_req & mem_ready
//  mem_ready  in   1       memory completes current request
//  RW_out, DA_out, MD_out, F_out, Data, VxorN_out  out  1/DA_W/2/DATA_W/DATA_W/1  to WB
//  MEM_FAULT  out  1       sticky timeout flag (0 without MEM_TIMEOUT_EN)
// BEHAVIOUR
//  - Stage register S {RW,DA,MD,MW,F,BUS_B,VxorN} loads inputs on each edge with STALL=0.
//  - memop = S.MW | (S.MD==1). FSM: RUN, WAIT, DONE (+FAULT wait-free abort path below).
//  - RUN, !memop: STALL=0, mem_req=0; outputs pass S; Data holds last load value.
//  - RUN, memop: mem_req=1, mem_we=S.MW, addr=S.F, wdata=S.BUS_B, STALL=1;
//    mem_ready=1 -> capture mem_rdata (load) into Data reg, go DONE; else go WAIT.
//  - WAIT: same request held stable, STALL=1; mem_ready=1 -> capture, go DONE.
//  - DONE: mem_req=0, STALL=0, outputs present S with new Data; next edge loads S, go RUN.
//  - While RUN-with-memop or WAIT: outputs are a bubble (RW_out=0, MD_out=0).
//  - Latency: non-mem op 1 cycle in stage; mem op = 2 + wait cycles (min 1 stall cycle).
//  - Store: Data not updated; RW_out = S.RW (normally 0). MD=2 needs no memory access.
//  - mem_ready while mem_req=0 ignored. Back-to-back mem ops: DONE always separates them.
//  - Reset (any state, incl. WAIT): S cleared to bubble, state RUN, Data=0, MEM_FAULT=0;
//    all outputs 0 after reset edge; in-flight request dropped (mem_req=0).
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: counter counts cycles in WAIT; reaching TIMEOUT_CYC without
//    mem_ready -> drop mem_req, go DONE with RW_out forced 0, Data unchanged, set MEM_FAULT
//    (sticky until RESET). Counter clears on entering WAIT.
//  MEM_TIMEOUT_EN undefined: WAIT lasts until mem_ready; no counter; MEM_FAULT tied 0.
// TESTING
//  1 ALU op RW=1,DA=3,MD=0,F=0x1234 -> next cycle RW_out=1,DA_out=3,F_out=0x1234,STALL=0.
//  2 Load MD=1,F=0x40, mem_ready after 3 cycles, rdata=0xCAFE -> STALL high 4 cycles,
//    RW_out=0 meanwhile, then DONE: RW_out=1, MD_out=1, Data=0xCAFE.
//  3 Store MW=1,F=0x80,BUS_B=0x55, ready same cycle -> mem_we=1, wdata=0x55, 1 stall cycle,
//    Data unchanged, RW_out=0.
//  4 Back-to-back loads (ready=1 always) -> each takes 2 cycles; DONE between; no lost op.
//  5 RESET during WAIT -> next cycle mem_req=0, STALL=0, all outputs 0, state RUN.
//  6 MEM_TIMEOUT_EN, TIMEOUT_CYC=4, ready never -> abort after 4 WAIT cycles, MEM_FAULT=1
//    and held, RW_out=0; pipeline resumes.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access pipeline stage between EX and WB: stage register, load/store handshake FSM, upstream stall.
// Optional build macro MEM_TIMEOUT_EN adds a WAIT-state timeout that aborts the access and sets a sticky MEM_FAULT.
module mem_access #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DA_W        = 5,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              RW,
    input  logic [DA_W-1:0]   DA,
    input  logic [1:0]        MD,
    input  logic              MW,
    input  logic [DATA_W-1:0] F,
    input  logic [DATA_W-1:0] BUS_B,
    input  logic              VxorN,
    output logic              STALL,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              RW_out,
    output logic [DA_W-1:0]   DA_out,
    output logic [1:0]        MD_out,
    output logic [DATA_W-1:0] F_out,
    output logic [DATA_W-1:0] Data,
    output logic              VxorN_out,
    output logic              MEM_FAULT
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              rw_q, mw_q, vx_q;
    logic [DA_W-1:0]   da_q;
    logic [1:0]        md_q;
    logic [DATA_W-1:0] f_q, b_q;
    logic [DATA_W-1:0] data_q, data_d;
    logic              memop_s, req_s, timeout_s, abort_s;

    assign memop_s = mw_q | (md_q == 2'd1);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, abort_q;

    // WAIT-cycle counter; held at zero outside WAIT so it is clear on every WAIT entry
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    assign timeout_s = (state_q == ST_WAIT) && !mem_ready && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign abort_s   = abort_q;
    assign MEM_FAULT = fault_q;

    // Timeout counter, one-cycle abort marker for DONE, sticky fault flag
    always_ff @(negedge CLOCK) begin
        if (RESET) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            abort_q <= timeout_s;
            fault_q <= fault_q | timeout_s;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign abort_s   = 1'b0;
    assign MEM_FAULT = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (memop_s) begin
                    state_d = mem_ready ? ST_DONE : ST_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (mem_ready || timeout_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // FSM outputs: request held from the RUN cycle of a memop through WAIT
    always_comb begin
        req_s = 1'b0;
        case (state_q)
            ST_RUN:  req_s = memop_s;
            ST_WAIT: req_s = 1'b1;
            ST_DONE: req_s = 1'b0;
            default: req_s = 1'b0;
        endcase
    end

    // Load data capture; ready without a live request is ignored
    always_comb begin
        data_d = data_q;
        if (req_s && mem_ready && !mw_q) begin
            data_d = mem_rdata;
        end else begin
            data_d = data_q;
        end
    end

    // State, stage register and load-data register
    always_ff @(negedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_RUN;
            rw_q    <= 1'b0;
            da_q    <= '0;
            md_q    <= 2'd0;
            mw_q    <= 1'b0;
            f_q     <= '0;
            b_q     <= '0;
            vx_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            if (!req_s) begin
                rw_q <= RW;
                da_q <= DA;
                md_q <= MD;
                mw_q <= MW;
                f_q  <= F;
                b_q  <= BUS_B;
                vx_q <= VxorN;
            end
        end
    end

    assign STALL     = req_s;
    assign mem_req   = req_s;
    assign mem_we    = req_s & mw_q;
    assign mem_addr  = f_q[ADDR_W-1:0];
    assign mem_wdata = b_q;
    // While the access is outstanding WB sees a bubble; an aborted access never writes back
    assign RW_out    = rw_q & ~req_s & ~abort_s;
    assign MD_out    = req_s ? 2'd0 : md_q;
    assign DA_out    = da_q;
    assign F_out     = f_q;
    assign Data      = data_q;
    assign VxorN_out = vx_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: driver pushes expected WB results, monitor pops on each presented op.
module tb_mem_access;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DA_W   = 5;

    logic              CLOCK = 1'b0;
    logic              RESET = 1'b1;
    logic              RW = 1'b0, MW = 1'b0, VxorN = 1'b0, mem_ready = 1'b0;
    logic [DA_W-1:0]   DA = '0;
    logic [1:0]        MD = 2'd0;
    logic [DATA_W-1:0] F = '0, BUS_B = '0, mem_rdata = '0;
    logic              STALL, mem_req, mem_we, RW_out, VxorN_out, MEM_FAULT;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, F_out, Data;
    logic [DA_W-1:0]   DA_out;
    logic [1:0]        MD_out;

    mem_access #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DA_W(DA_W), .TIMEOUT_CYC(4)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .RW(RW), .DA(DA), .MD(MD), .MW(MW), .F(F), .BUS_B(BUS_B),
        .VxorN(VxorN), .STALL(STALL), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .RW_out(RW_out),
        .DA_out(DA_out), .MD_out(MD_out), .F_out(F_out), .Data(Data), .VxorN_out(VxorN_out),
        .MEM_FAULT(MEM_FAULT)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic        rw;
        logic [4:0]  da;
        logic [1:0]  md;
        logic [31:0] f;
        logic [31:0] data;
        logic        vx;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    int          rdy_lat = 0;
    int          resp_cnt = 0;
    bit          spur = 1'b0;
    logic [31:0] rdata_val = '0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    int          st;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: bubble while stalled, otherwise pop and compare each presented op (DA_out != 0)
    always @(posedge CLOCK) begin
        if (mon_en) begin
            if (STALL === 1'b1) begin
                chk("bubble_rw", {31'd0, RW_out}, 32'd0);
                chk("bubble_md", {30'd0, MD_out}, 32'd0);
            end else if (DA_out != '0) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_op: got DA_out=%0d, expected no op", DA_out);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("wb_rw",   {31'd0, RW_out}, {31'd0, e.rw});
                    chk("wb_da",   {27'd0, DA_out}, {27'd0, e.da});
                    chk("wb_md",   {30'd0, MD_out}, {30'd0, e.md});
                    chk("wb_f",    F_out, e.f);
                    chk("wb_data", Data, e.data);
                    chk("wb_vx",   {31'd0, VxorN_out}, {31'd0, e.vx});
                end
            end
        end
    end

    // Memory responder: checks the request and raises ready after rdy_lat request cycles
    initial begin
        forever begin
            @(posedge CLOCK);
            #1;
            if (mem_req === 1'b1) begin
                chk("req_we",    {31'd0, mem_we}, {31'd0, exp_we});
                chk("req_addr",  mem_addr, exp_addr);
                chk("req_wdata", mem_wdata, exp_wdata);
                if (resp_cnt == rdy_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = rdata_val;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 32'hDEAD_BEEF;
                end
                resp_cnt++;
            end else begin
                resp_cnt  = 0;
                mem_ready = spur;
                mem_rdata = 32'hBAD0_BAD0;
            end
        end
    end

    // Present one op, wait until the stage accepts it, return stall cycles spent on the previous op
    task automatic issue(input logic rw, input logic [4:0] da, input logic [1:0] md, input logic mw,
                         input logic [31:0] f, input logic [31:0] b, input logic vx,
                         input logic exp_rw, input logic [31:0] exp_data,
                         input int lat, input logic [31:0] rdata, input bit spurious,
                         output int stalls);
        RW = rw; DA = da; MD = md; MW = mw; F = f; BUS_B = b; VxorN = vx;
        stalls = 0;
        while (STALL !== 1'b0 && stalls < 200) begin
            @(posedge CLOCK);
            #1;
            stalls++;
        end
        if (stalls >= 200) begin
            tests++;
            fails++;
            $display("FAIL stall_bound: got STALL held 200 cycles, expected release");
        end
        rdy_lat   = lat;
        rdata_val = rdata;
        spur      = spurious;
        exp_we    = mw;
        exp_addr  = f;
        exp_wdata = b;
        if (da != 5'd0) sb_q.push_back('{exp_rw, da, md, f, exp_data, vx});
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {31'd0, STALL}, 32'd0);
        chk({tag, "_req"},   {31'd0, mem_req}, 32'd0);
        chk({tag, "_we"},    {31'd0, mem_we}, 32'd0);
        chk({tag, "_addr"},  mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_rw"},    {31'd0, RW_out}, 32'd0);
        chk({tag, "_da"},    {27'd0, DA_out}, 32'd0);
        chk({tag, "_md"},    {30'd0, MD_out}, 32'd0);
        chk({tag, "_f"},     F_out, 32'd0);
        chk({tag, "_data"},  Data, 32'd0);
        chk({tag, "_vx"},    {31'd0, VxorN_out}, 32'd0);
        chk({tag, "_fault"}, {31'd0, MEM_FAULT}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLOCK);
        #1;
        chk_all_zero("reset");
        RESET  = 1'b0;
        mon_en = 1'b1;

        // ALU op, then MD=2 (set-less-than) op: no memory access
        issue(1'b1, 5'd3, 2'd0, 1'b0, 32'h1234, 32'h0, 1'b0, 1'b1, 32'h0, 0, 32'h0, 1'b0, st);
        issue(1'b1, 5'd4, 2'd2, 1'b0, 32'h7,    32'h0, 1'b1, 1'b1, 32'h0, 0, 32'h0, 1'b0, st);
        chk("alu_stall", st, 32'd0);
        // Load with ready on the fourth request cycle
        issue(1'b1, 5'd5, 2'd1, 1'b0, 32'h40, 32'h99, 1'b0, 1'b1, 32'hCAFE, 3, 32'hCAFE, 1'b0, st);
        chk("md2_stall", st, 32'd0);
        // Store, ready in the same cycle: Data keeps the last load value
        issue(1'b0, 5'd6, 2'd0, 1'b1, 32'h80, 32'h55, 1'b0, 1'b0, 32'hCAFE, 0, 32'h0, 1'b0, st);
        chk("load_stall", st, 32'd4);
        // ALU op with ready pulsing while no request is live
        issue(1'b1, 5'd7, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0, 1'b1, 32'hCAFE, 0, 32'h0, 1'b1, st);
        chk("store_stall", st, 32'd1);
        // Back-to-back loads with ready always
        issue(1'b1, 5'd8,  2'd1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 32'h1111, 0, 32'h1111, 1'b0, st);
        chk("spur_stall", st, 32'd0);
        issue(1'b1, 5'd9,  2'd1, 1'b0, 32'h104, 32'h0, 1'b0, 1'b1, 32'h2222, 0, 32'h2222, 1'b0, st);
        chk("b2b_stall_1", st, 32'd1);
        issue(1'b1, 5'd10, 2'd1, 1'b0, 32'h108, 32'h0, 1'b1, 1'b1, 32'h3333, 0, 32'h3333, 1'b0, st);
        chk("b2b_stall_2", st, 32'd1);
        issue(1'b0, 5'd0,  2'd0, 1'b0, 32'h0,   32'h0, 1'b0, 1'b0, 32'h0,    0, 32'h0,    1'b0, st);
        chk("b2b_stall_3", st, 32'd1);

        // Reset while a load sits in WAIT
        issue(1'b1, 5'd0, 2'd1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, 1000, 32'h0, 1'b0, st);
        RW = 1'b0; DA = '0; MD = 2'd0; MW = 1'b0; F = '0; BUS_B = '0; VxorN = 1'b0;
        @(posedge CLOCK);
        #1;
        chk("wait_stall", {31'd0, STALL}, 32'd1);
        chk("wait_req",   {31'd0, mem_req}, 32'd1);
        RESET = 1'b1;
        @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        chk_all_zero("rst_wait");
        issue(1'b1, 5'd11, 2'd0, 1'b0, 32'hABC, 32'h0, 1'b1, 1'b1, 32'h0, 0, 32'h0, 1'b0, st);

`ifdef MEM_TIMEOUT_EN
        // Load that never completes: abort after 4 WAIT cycles
        issue(1'b1, 5'd12, 2'd1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0, 1000, 32'h0, 1'b0, st);
        issue(1'b1, 5'd13, 2'd0, 1'b0, 32'h5,   32'h0, 1'b0, 1'b1, 32'h0, 0,    32'h0, 1'b0, st);
        chk("timeout_stall", st, 32'd5);
        chk("fault_set", {31'd0, MEM_FAULT}, 32'd1);
        issue(1'b0, 5'd0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b0, st);
        issue(1'b0, 5'd0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b0, st);
        chk("fault_sticky", {31'd0, MEM_FAULT}, 32'd1);
`else
        issue(1'b0, 5'd0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b0, st);
        chk("fault_tied", {31'd0, MEM_FAULT}, 32'd0);
`endif
        repeat (3) @(posedge CLOCK);
        #1;
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
